// File: rtl/issue_execute_fifo_pkg.sv
// issue_execute_fifo_pkg: issue->execute pack type and per-unit queue depths
package issue_execute_fifo_pkg;
  localparam int ALU_FIFO_DEPTH = 4;
  localparam int BRU_FIFO_DEPTH = 4;
  localparam int CSR_FIFO_DEPTH = 2;
  localparam int DIV_FIFO_DEPTH = 2;
  localparam int MUL_FIFO_DEPTH = 4;
  localparam int LSU_FIFO_DEPTH = 8;
  typedef enum logic [2:0] {
    UNIT_ALU, UNIT_BRU, UNIT_CSR, UNIT_DIV, UNIT_MUL, UNIT_LSU
  } op_unit_t;
  typedef struct packed {
    logic [5:0]  rob_id;
    op_unit_t    unit;
    logic [4:0]  rd;
    logic [31:0] imm;
  } issue_execute_pack_t;
endpackage

// File: rtl/issue_execute_fifo_if.sv
// issue_execute_fifo_if: issue-side push and execute-side pop/head signals
interface issue_execute_fifo_if #(parameter int DEPTH = 4);
  import issue_execute_fifo_pkg::*;
  localparam int DEPTH_W = $clog2(DEPTH);
  issue_execute_pack_t data_in, data_out;
  logic push, full, data_out_valid, pop, flush;
  logic [DEPTH_W:0] count;
  modport master (output data_in, push, pop, flush, input full, data_out, data_out_valid, count);
  modport slave (input data_in, push, pop, flush, output full, data_out, data_out_valid, count);
endinterface

// File: rtl/issue_execute_fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with increment and synchronous clear
module fifo_ptr #(parameter int W = 3) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else ptr <= clr ? '0 : inc ? ptr + 1'b1 : ptr;
endmodule

// File: rtl/issue_execute_fifo.sv
// issue_execute_fifo: decoupling queue between issue and one execute unit
module issue_execute_fifo
  import issue_execute_fifo_pkg::*;
#(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  issue_execute_fifo_if.slave f
);
  localparam int DW = $clog2(DEPTH);
  issue_execute_pack_t mem [DEPTH];
  logic [DW:0] rptr, wptr;
  logic do_push, do_pop;
  assign f.full = (rptr[DW-1:0] == wptr[DW-1:0]) && (rptr[DW] != wptr[DW]);
  assign f.data_out_valid = rptr != wptr;
  assign f.count = wptr - rptr;
  assign f.data_out = mem[rptr[DW-1:0]];
  // a same-cycle pop never frees room for this cycle's push
  assign do_push = f.push && !f.full && !f.flush;
  assign do_pop = f.pop && f.data_out_valid;
  fifo_ptr #(.W(DW + 1)) u_rptr (.clk(clk), .rst(rst), .inc(do_pop), .clr(f.flush), .ptr(rptr));
  fifo_ptr #(.W(DW + 1)) u_wptr (.clk(clk), .rst(rst), .inc(do_push), .clr(f.flush), .ptr(wptr));
  always_ff @(posedge clk)
    if (do_push) mem[wptr[DW-1:0]] <= f.data_in;
  a_push_full: assert property (@(posedge clk) disable iff (!rst) !(f.push && f.full))
    else $warning("issue_execute_fifo: push while full");
  a_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(f.pop && !f.data_out_valid))
    else $warning("issue_execute_fifo: pop while empty");
endmodule

// File: doc/issue_execute_fifo.md
Name: issue_execute_fifo

Overview:
Decoupling FIFO between the issue stage and one execute unit, instantiated once per unit (ALU, BRU, CSR, DIV, MUL, LSU). Issue pushes issue_execute_pack_t entries. The execute unit sees the head entry combinationally through data_out/data_out_valid and pops it on the same cycle it consumes it. A commit-driven flush empties the queue in one cycle.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
DEPTH_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
data_in  input  $bits(issue_execute_pack_t)  entry from issue
push  input  1  write data_in this cycle
full  output  1  no free entry; issue must not push
data_out  output  $bits(issue_execute_pack_t)  head entry (combinational from storage)
data_out_valid  output  1  FIFO non-empty
pop  input  1  execute unit consumes head this cycle
flush  input  1  discard all entries (commit_feedback_pack.enable && flush)
count  output  DEPTH_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0, async): rptr=0, wptr=0, count=0, full=0, data_out_valid=0. Storage is not reset; data_out is don't-care while data_out_valid=0.
- Pointers are DEPTH_W+1 bits, with the wrap bit as MSB.
  - empty = (rptr==wptr).
  - full = (rptr[DEPTH_W-1:0]==wptr[DEPTH_W-1:0]) && (rptr[DEPTH_W]!=wptr[DEPTH_W]).
  - count = wptr - rptr (modulo 2^(DEPTH_W+1)).
- All state updates on posedge clk when rst=1.
- Push accepted = push && !full, using full from the current state (a pop in the same cycle does not free a slot for that cycle's push). Accepted push writes mem[wptr[DEPTH_W-1:0]] and increments wptr.
- Pop accepted = pop && data_out_valid. Accepted pop increments rptr. Pop when empty is ignored and does not move rptr.
- Simultaneous accepted push and pop: both pointers advance, count unchanged. When count==1, the new entry becomes head the next cycle.
- Push-through is not supported. An entry pushed in cycle N is visible on data_out at N+1 at the earliest.
- Latency: push to data_out_valid = 1 cycle; pop to next head = 1 cycle.
- flush=1 has priority over push and pop in the same cycle: rptr<=0, wptr<=0; the pushed entry is dropped. data_out_valid=0 and full=0 from the next cycle.
- Wrap-around: pointers wrap naturally. The wrap bit distinguishes full from empty at equal indices.
- Illegal-use detection (simulation only): assertion fires on push while full and on pop while empty. RTL behaviour is as defined above regardless.
- Outputs full, data_out_valid and count are pure functions of registered pointers; no combinational path from push/pop/flush to any output.

Decomposition:
- issue_execute_pack_t, arg_src_t, op_t, op_unit_t and the sub_op union already live in the shared common package; no new typedefs needed.
- Add the per-unit depth constants to config.svh: ALU_FIFO_DEPTH, BRU_FIFO_DEPTH, CSR_FIFO_DEPTH, DIV_FIFO_DEPTH, MUL_FIFO_DEPTH, LSU_FIFO_DEPTH.
- One natural sub-module: fifo_ptr, a wrap-bit pointer register with inc/clear inputs, instantiated twice (read and write). Storage stays in the top module.

Test Plan:
1. Reset, then idle 2 cycles -> data_out_valid=0, full=0, count=0. Pop with empty FIFO -> count stays 0, no assertion side effect on pointers.
2. Push 4 packs with rob_id=1,2,3,4 (DEPTH=4), no pop -> count=4, full=1 after 4th edge. Fifth push with rob_id=5 -> ignored, count=4.
3. From full, pop every cycle -> data_out.rob_id sequence 1,2,3,4, then data_out_valid=0, count=0.
4. Streaming: with count=1 (head rob_id=7), push rob_id=8 and pop simultaneously -> next cycle count=1, data_out.rob_id=8. Continue alternating through 10 entries -> pointers wrap, order preserved, no drop.
5. Full plus simultaneous push and pop -> pop accepted, push rejected, count=3. Next cycle push accepted -> count=4.
6. count=3, then flush=1 together with push and pop -> next cycle count=0, data_out_valid=0, full=0. Following push of rob_id=9 -> data_out.rob_id=9 one cycle later. Async rst=0 asserted mid-stream -> outputs clear immediately, without waiting for a clock edge.
